ps2_host_tx: RTL

- Host-to-device transmitter for the PS/2 keyboard port. It sends command bytes to the keyboard, for example 0xED for the LEDs or 0xFF for reset.
- It is the opposite direction to the existing PS/2 receive path that feeds the encrypt/decrypt top level.
- It drives the open-collector PS2_CLK and PS2_DATA lines through active-high pull-low enables. The top-level pads implement those enables as tristates.

---
 rtl/ps2_host_tx.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command transmitter driving open-collector pull-low enables
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 10000,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_vld,
    output logic       tx_rdy,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_err,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);
    localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, INHIBIT, REQ, SEND, ACK, WAIT_IDLE} state_t;

    state_t           state, state_nxt;
    logic [1:0]       clk_sync, data_sync;
    logic             clk_prev;
    logic             fall, clk_s, data_s;
    logic [8:0]       shreg, shreg_nxt;
    logic [3:0]       bit_cnt, bit_cnt_nxt;
    logic [INH_W-1:0] inh_cnt, inh_cnt_nxt;
    logic [TO_W-1:0]  to_cnt, to_cnt_nxt;
    logic             err_flag, err_flag_nxt;
    logic             bit_oe, bit_oe_nxt;
    logic             done_nxt, err_nxt;
    logic             abort;

    assign clk_s  = clk_sync[1];
    assign data_s = data_sync[1];
    assign fall   = clk_prev & ~clk_s;

    // Synchronisers idle high so reset release never fabricates a falling edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
            clk_prev  <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk_in};
            data_sync <= {data_sync[0], ps2_data_in};
            clk_prev  <= clk_s;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            shreg    <= '0;
            bit_cnt  <= '0;
            inh_cnt  <= '0;
            to_cnt   <= '0;
            err_flag <= 1'b0;
            bit_oe   <= 1'b0;
            tx_done  <= 1'b0;
            tx_err   <= 1'b0;
        end else begin
            state    <= state_nxt;
            shreg    <= shreg_nxt;
            bit_cnt  <= bit_cnt_nxt;
            inh_cnt  <= inh_cnt_nxt;
            to_cnt   <= to_cnt_nxt;
            err_flag <= err_flag_nxt;
            bit_oe   <= bit_oe_nxt;
            tx_done  <= done_nxt;
            tx_err   <= err_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        shreg_nxt    = shreg;
        bit_cnt_nxt  = bit_cnt;
        inh_cnt_nxt  = inh_cnt;
        to_cnt_nxt   = to_cnt;
        err_flag_nxt = err_flag;
        bit_oe_nxt   = bit_oe;
        done_nxt     = 1'b0;
        err_nxt      = 1'b0;
        abort        = 1'b0;
        case (state)
            IDLE: begin
                if (tx_vld) begin
                    shreg_nxt   = {~^tx_data, tx_data};
                    inh_cnt_nxt = '0;
                    state_nxt   = INHIBIT;
                end
            end
            INHIBIT: begin
                if (inh_cnt == INH_LAST) begin
                    inh_cnt_nxt = '0;
                    state_nxt   = REQ;
                end else begin
                    inh_cnt_nxt = inh_cnt + 1'b1;
                end
            end
            REQ: begin
                bit_oe_nxt  = 1'b1;
                bit_cnt_nxt = '0;
                to_cnt_nxt  = '0;
                state_nxt   = SEND;
            end
            SEND: begin
                if (fall) begin
                    to_cnt_nxt = '0;
                    if (bit_cnt == 4'd9) begin
                        bit_oe_nxt = 1'b0;
                        state_nxt  = ACK;
                    end else begin
                        bit_oe_nxt  = ~shreg[0];
                        shreg_nxt   = {1'b0, shreg[8:1]};
                        bit_cnt_nxt = bit_cnt + 1'b1;
                    end
                end else if (to_cnt == TO_LAST) begin
                    abort = 1'b1;
                end else begin
                    to_cnt_nxt = to_cnt + 1'b1;
                end
            end
            ACK: begin
                if (fall) begin
                    to_cnt_nxt = '0;
                    if (data_s) err_flag_nxt = 1'b1;
                    state_nxt = WAIT_IDLE;
                end else if (to_cnt == TO_LAST) begin
                    abort = 1'b1;
                end else begin
                    to_cnt_nxt = to_cnt + 1'b1;
                end
            end
            WAIT_IDLE: begin
                if (clk_s && data_s) begin
                    done_nxt     = 1'b1;
                    err_nxt      = err_flag;
                    err_flag_nxt = 1'b0;
                    state_nxt    = IDLE;
                end else if (fall) begin
                    to_cnt_nxt = '0;
                end else if (to_cnt == TO_LAST) begin
                    abort = 1'b1;
                end else begin
                    to_cnt_nxt = to_cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
        // Device went silent: give up, release the bus and report failure
        if (abort) begin
            state_nxt    = IDLE;
            bit_oe_nxt   = 1'b0;
            err_flag_nxt = 1'b0;
            to_cnt_nxt   = '0;
            done_nxt     = 1'b1;
            err_nxt      = 1'b1;
        end
    end

    assign tx_rdy      = (state == IDLE);
    assign tx_busy     = ~tx_rdy;
    assign ps2_clk_oe  = (state == INHIBIT) || (state == REQ);
    assign ps2_data_oe = (state == REQ) || ((state == SEND) && bit_oe);

endmodule
